// File: rtl/sha256_pkg.sv
// sha256_pkg
//   Shared constants and types for the sha256 front end of the hash160
//   pipeline: block geometry, the FIPS 180-4 padding constants and the
//   message padder state encoding.
package sha256_pkg;

    localparam int BLOCK_BYTES     = 64;
    localparam int LEN_FIELD_BYTES = 8;
    localparam int LEN_OFFSET      = BLOCK_BYTES - LEN_FIELD_BYTES;  // 56
    localparam logic [7:0] PAD_BYTE = 8'h80;

    // Padder states:
    //   FILL   - accepting message bytes
    //   PAD    - one cycle: 0x80 marker + zero tail (+ length if it fits)
    //   LENBLK - one cycle: all-zero block carrying only the length field
    //   EMIT   - presenting a block to the core, waiting for its ready
    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_PAD    = 2'd1,
        ST_LENBLK = 2'd2,
        ST_EMIT   = 2'd3
    } pad_state_e;

    // Byte idx (LEN_OFFSET..BLOCK_BYTES-1) of the big-endian 64-bit length.
    function automatic logic [7:0] len_byte(input logic [63:0] len, input int idx);
        return len[8*(BLOCK_BYTES-1-idx) +: 8];
    endfunction

endpackage

// File: rtl/sha256_msg_padder.sv
// sha256_msg_padder
//   Turns a byte stream (valid/ready/last) into FIPS 180-4 padded 512-bit
//   blocks for the sha256 core: message bytes, a 0x80 marker, zero fill and
//   the 64-bit big-endian message bit length in the last 8 bytes.
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   i_valid/i_data  message byte, transferred when i_valid & o_ready
//   i_last          marks the final byte of the message (qualified by i_valid)
//   o_ready         padder can take a byte (only while filling)
//   o_block         padded block, byte 0 at [511:504], byte 63 at [7:0]
//   o_block_valid   o_block is valid; held with flags until i_block_ready
//   o_block_first   first block of a message (core reloads H0)
//   o_block_last    final block of a message (digest is complete after it)
//   i_block_ready   core accepts o_block
module sha256_msg_padder
    import sha256_pkg::*;
#(
    parameter int LEN_W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_valid,
    input  logic [7:0]   i_data,
    input  logic         i_last,
    output logic         o_ready,
    output logic [511:0] o_block,
    output logic         o_block_valid,
    output logic         o_block_first,
    output logic         o_block_last,
    input  logic         i_block_ready
);

    pad_state_e              r_state;
    logic [5:0]              r_ptr;        // next byte slot within the block
    logic [LEN_W-1:0]        r_count;      // message bytes so far (wraps)
    logic                    r_msg_done;   // final message byte received
    logic                    r_pad_done;   // 0x80 marker already placed
    logic                    r_started;    // a block of this message was emitted
    logic                    r_ready;
    logic                    r_valid;
    logic                    r_first;
    logic                    r_last;
    // Ascending packed index so element 0 lands in the top byte of o_block.
    logic [0:BLOCK_BYTES-1][7:0] r_blk;

    logic                    w_xfer;
    logic [63:0]             w_len;
    logic [0:BLOCK_BYTES-1][7:0] w_pad_blk;
    logic [0:BLOCK_BYTES-1][7:0] w_len_blk;

    assign w_xfer = i_valid & r_ready;
    assign w_len  = 64'({r_count, 3'b000});

    assign o_ready       = r_ready;
    assign o_block       = r_blk;
    assign o_block_valid = r_valid;
    assign o_block_first = r_first;
    assign o_block_last  = r_last;

    // Whole-block rewrite images for PAD and LENBLK. Bytes below ptr keep
    // message data, ptr gets the marker, everything above is cleared, and
    // the length overwrites the tail only when it still fits (ptr <= 55).
    always_comb begin
        w_pad_blk = r_blk;
        w_len_blk = '0;
        for (int i = 0; i < BLOCK_BYTES; i++) begin
            if (6'(i) == r_ptr)
                w_pad_blk[i] = PAD_BYTE;
            else if (6'(i) > r_ptr)
                w_pad_blk[i] = 8'h00;
            if (i >= LEN_OFFSET) begin
                if (r_ptr < 6'(LEN_OFFSET))
                    w_pad_blk[i] = len_byte(w_len, i);
                w_len_blk[i] = len_byte(w_len, i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_FILL;
            r_ptr      <= '0;
            r_count    <= '0;
            r_msg_done <= 1'b0;
            r_pad_done <= 1'b0;
            r_started  <= 1'b0;
            r_ready    <= 1'b0;
            r_valid    <= 1'b0;
            r_first    <= 1'b0;
            r_last     <= 1'b0;
            r_blk      <= '0;
        end else begin
            case (r_state)
                ST_FILL: begin
                    // o_ready is registered, so it comes up one cycle after reset.
                    r_ready <= 1'b1;
                    if (w_xfer) begin
                        r_blk[r_ptr] <= i_data;
                        r_ptr        <= r_ptr + 6'd1;
                        r_count      <= r_count + 1'b1;
                        if (i_last)
                            r_msg_done <= 1'b1;
                        if (r_ptr == 6'(BLOCK_BYTES-1)) begin
                            // Block full of data: emit it, padding follows later.
                            r_state   <= ST_EMIT;
                            r_ready   <= 1'b0;
                            r_valid   <= 1'b1;
                            r_first   <= !r_started;
                            r_last    <= 1'b0;
                            r_started <= 1'b1;
                        end else if (i_last) begin
                            r_state <= ST_PAD;
                            r_ready <= 1'b0;
                        end
                    end
                end

                ST_PAD: begin
                    r_blk      <= w_pad_blk;
                    r_pad_done <= 1'b1;
                    r_state    <= ST_EMIT;
                    r_valid    <= 1'b1;
                    r_first    <= !r_started;
                    r_last     <= (r_ptr < 6'(LEN_OFFSET));
                    r_started  <= 1'b1;
                end

                ST_LENBLK: begin
                    r_blk     <= w_len_blk;
                    r_state   <= ST_EMIT;
                    r_valid   <= 1'b1;
                    r_first   <= !r_started;
                    r_last    <= 1'b1;
                    r_started <= 1'b1;
                end

                ST_EMIT: begin
                    if (i_block_ready) begin
                        r_valid <= 1'b0;
                        r_first <= 1'b0;
                        r_last  <= 1'b0;
                        r_ptr   <= '0;
                        if (r_last) begin
                            // Message complete: arm for the next one.
                            r_state    <= ST_FILL;
                            r_ready    <= 1'b1;
                            r_count    <= '0;
                            r_msg_done <= 1'b0;
                            r_pad_done <= 1'b0;
                            r_started  <= 1'b0;
                        end else if (r_pad_done) begin
                            r_state <= ST_LENBLK;
                        end else if (r_msg_done) begin
                            // Message ended exactly on a block boundary.
                            r_state <= ST_PAD;
                        end else begin
                            r_state <= ST_FILL;
                            r_ready <= 1'b1;
                        end
                    end
                end

                default: begin
                    r_state <= ST_FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_msg_padder.sv
module tb_sha256_msg_padder;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         i_valid = 1'b0;
    logic [7:0]   i_data = 8'h00;
    logic         i_last = 1'b0;
    logic         o_ready;
    logic [511:0] o_block;
    logic         o_block_valid;
    logic         o_block_first;
    logic         o_block_last;
    logic         i_block_ready = 1'b0;

    always #5 clk = ~clk;

    sha256_msg_padder #(.LEN_W(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_valid       (i_valid),
        .i_data        (i_data),
        .i_last        (i_last),
        .o_ready       (o_ready),
        .o_block       (o_block),
        .o_block_valid (o_block_valid),
        .o_block_first (o_block_first),
        .o_block_last  (o_block_last),
        .i_block_ready (i_block_ready)
    );

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [511:0] blk;
        logic         first;
        logic         last;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   ready_mode = 0;   // 0 random, 1 always ready, 2 never ready

    task automatic check(input bit ok, input string nm, input string detail);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: %s", nm, detail);
        end
    endtask

    // Reference: pad the whole message as a byte array, then cut into blocks.
    function automatic void model_push(input bq_t m);
        bq_t         p;
        logic [63:0] len;
        int          nb;
        exp_t        e;
        p   = m;
        len = 64'(m.size()) * 64'd8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(len[8*i +: 8]);
        nb = p.size() / 64;
        for (int b = 0; b < nb; b++) begin
            e.blk = '0;
            for (int j = 0; j < 64; j++) e.blk[511-8*j -: 8] = p[b*64+j];
            e.first = (b == 0);
            e.last  = (b == nb - 1);
            sbq.push_back(e);
        end
    endfunction

    // Block-ready driver.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: i_block_ready = ($urandom_range(0, 99) < 60);
                1: i_block_ready = 1'b1;
                default: i_block_ready = 1'b0;
            endcase
        end
    end

    // Monitor / scoreboard.
    logic         stalled = 1'b0;
    logic [511:0] held_blk;
    logic         held_first, held_last;
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && o_block_valid) begin
            check(!o_ready, "ready_in_emit", $sformatf("o_ready=%0b want 0", o_ready));
            if (stalled)
                check(o_block == held_blk && o_block_first == held_first && o_block_last == held_last,
                      "hold_stable", $sformatf("first=%0b last=%0b got %h want %h",
                      o_block_first, o_block_last, o_block, held_blk));
            if (i_block_ready) begin
                stalled = 1'b0;
                if (sbq.size() == 0) begin
                    check(1'b0, "unexpected_block", $sformatf("got %h", o_block));
                end else begin
                    e = sbq.pop_front();
                    check(o_block == e.blk, "block_data", $sformatf("got %h want %h", o_block, e.blk));
                    check(o_block_first == e.first && o_block_last == e.last, "block_flags",
                          $sformatf("first/last got %0b%0b want %0b%0b",
                          o_block_first, o_block_last, e.first, e.last));
                end
            end else begin
                stalled    = 1'b1;
                held_blk   = o_block;
                held_first = o_block_first;
                held_last  = o_block_last;
            end
        end else begin
            stalled = 1'b0;
        end
    end

    task automatic send_msg(input bq_t m, input bit with_last, input int gap_pct);
        int tries;
        for (int k = 0; k < m.size(); k++) begin
            while ($urandom_range(0, 99) < gap_pct) begin
                i_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            i_valid = 1'b1;
            i_data  = m[k];
            i_last  = with_last && (k == m.size() - 1);
            tries = 0;
            forever begin
                @(negedge clk);
                if (o_ready) begin
                    @(posedge clk);
                    #1;
                    break;
                end
                tries++;
                if (tries > 2000) begin
                    check(1'b0, "byte_accept_timeout", $sformatf("byte %0d not accepted", k));
                    break;
                end
                @(posedge clk);
                #1;
            end
            // Between bytes drive junk i_last without i_valid; it must be ignored.
            i_valid = 1'b0;
            i_last  = $urandom_range(0, 1);
            i_data  = 8'($urandom);
        end
        i_last = 1'b0;
    endtask

    // Counts negedges until o_block_valid is seen.
    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!o_block_valid && n < 200);
    endtask

    task automatic drain();
        int n = 0;
        while ((sbq.size() != 0 || o_block_valid) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check(sbq.size() == 0, "drain", $sformatf("%0d blocks outstanding", sbq.size()));
        @(posedge clk);
        #1;
    endtask

    function automatic bq_t rand_msg(input int len);
        bq_t q;
        for (int i = 0; i < len; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    initial begin
        bq_t  m;
        exp_t e;
        int   n;
        int   lens[$];

        // Reset state.
        repeat (3) @(negedge clk);
        check(o_ready == 0 && o_block_valid == 0 && o_block_first == 0 && o_block_last == 0,
              "reset_flags", $sformatf("rdy=%0b v=%0b f=%0b l=%0b",
              o_ready, o_block_valid, o_block_first, o_block_last));
        check(o_block == '0, "reset_block", $sformatf("got %h", o_block));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check(o_ready == 1'b1, "ready_after_reset", $sformatf("o_ready=%0b want 1", o_ready));
        @(posedge clk);
        #1;

        // "abc": single block with a literal expectation and latency 2.
        ready_mode = 1;
        m = '{8'h61, 8'h62, 8'h63};
        e.blk = {32'h61626380, 416'h0, 64'h18};
        e.first = 1'b1;
        e.last  = 1'b1;
        sbq.push_back(e);
        send_msg(m, 1'b1, 0);
        wait_valid(n);
        check(n == 2, "abc_latency", $sformatf("valid after %0d cycles want 2", n));
        drain();

        // 64-byte message: data block appears one cycle after byte 63.
        m = rand_msg(64);
        model_push(m);
        send_msg(m, 1'b1, 0);
        wait_valid(n);
        check(n == 1, "full_block_latency", $sformatf("valid after %0d cycles want 1", n));
        drain();

        // Boundary lengths with backpressure and input gaps.
        ready_mode = 0;
        lens = '{1, 54, 55, 56, 57, 63, 65, 119, 120, 128};
        foreach (lens[i]) begin
            m = rand_msg(lens[i]);
            model_push(m);
            send_msg(m, 1'b1, 20);
            drain();
        end

        // Core stalls 10 cycles on a presented block.
        ready_mode = 2;
        m = rand_msg(64);
        model_push(m);
        send_msg(m, 1'b1, 0);
        wait_valid(n);
        repeat (10) begin
            @(negedge clk);
            check(o_block_valid && !o_ready, "stall_state",
                  $sformatf("valid=%0b rdy=%0b want 1/0", o_block_valid, o_ready));
        end
        ready_mode = 0;
        drain();

        // Reset in the middle of filling, then a clean "abc".
        ready_mode = 1;
        m = rand_msg(20);
        send_msg(m, 1'b0, 0);
        rst_n = 1'b0;
        #1;
        check(o_ready == 0 && o_block_valid == 0 && o_block_first == 0 && o_block_last == 0
              && o_block == '0, "midfill_reset",
              $sformatf("rdy=%0b v=%0b f=%0b l=%0b blk=%h",
              o_ready, o_block_valid, o_block_first, o_block_last, o_block));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        m = '{8'h61, 8'h62, 8'h63};
        e.blk = {32'h61626380, 416'h0, 64'h18};
        e.first = 1'b1;
        e.last  = 1'b1;
        sbq.push_back(e);
        send_msg(m, 1'b1, 0);
        wait_valid(n);
        check(n == 2, "abc_after_reset_latency", $sformatf("valid after %0d cycles want 2", n));
        drain();

        // Random messages.
        ready_mode = 0;
        for (int t = 0; t < 25; t++) begin
            m = rand_msg($urandom_range(1, 200));
            model_push(m);
            send_msg(m, 1'b1, $urandom_range(0, 40));
            drain();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
